// File: rtl/gpio_rx_pkg.sv
// gpio_rx_pkg: capture FSM state type and width helpers shared by the GPIO capture engine
package gpio_rx_pkg;
  typedef enum logic [2:0] {IDLE, REQ, CAP, ACK, ADV, DONE} state_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/gpio_rx_buffer_clk_en_div.sv
// clk_en_div: one-cycle clock-enable pulse every CLK_DIV clk cycles
module clk_en_div
  import gpio_rx_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);
  localparam int W = cnt_w(CLK_DIV);
  logic [W-1:0] r_cnt;
  assign o_tick = (r_cnt == W'(CLK_DIV - 1));
  // free-running divider, wraps on the tick cycle
  always_ff @(posedge clk)
    if (!rst) r_cnt <= '0;
    else r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/gpio_rx_buffer.sv
// gpio_rx_buffer: req/ready/ack word capture into a DEPTH-entry buffer with read port and display tap
module gpio_rx_buffer
  import gpio_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 40,
  parameter int CLK_DIV    = 4,
  parameter int CONTINUOUS = 0,
  parameter int ACK_TO     = 255,
  parameter int TAP_IDX    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_n,
  input  logic                       abort,
  output logic                       readssr_req,
  input  logic                       byte_ready,
  input  logic [DATA_W-1:0]          byte_in,
  output logic                       byte_ack,
  input  logic [cnt_w(DEPTH)-1:0]    rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  output logic [DATA_W-1:0]          tap_data,
  output logic [cnt_w(DEPTH+1)-1:0]  count,
  output logic                       wrapped,
  output logic                       done,
  output logic                       err_timeout
);
  localparam int AW = cnt_w(DEPTH);
  localparam int CW = cnt_w(DEPTH + 1);
  localparam int TW = cnt_w(ACK_TO + 1);
  state_t            r_state, w_next;
  logic [1:0]        r_sync;
  logic              w_ready_s, w_tick, w_last, w_to;
  logic [AW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_timer;
  logic              r_wrapped, r_done, r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (.clk(clk), .rst(rst), .o_tick(w_tick));

  assign w_ready_s   = r_sync[1];
  assign w_last      = (r_idx == AW'(DEPTH - 1));
  assign w_to        = (r_timer == TW'(ACK_TO - 1));
  assign readssr_req = (r_state == REQ);
  assign byte_ack    = (r_state == ACK);
  assign count       = r_cnt;
  assign wrapped     = r_wrapped;
  assign done        = r_done;
  assign err_timeout = r_err;

  // next state: advances only on tick, abort overrides immediately
  always_comb begin
    w_next = r_state;
    if (w_tick)
      case (r_state)
        IDLE:    w_next = start_n ? IDLE : REQ;
        REQ:     w_next = w_ready_s ? CAP : REQ;
        CAP:     w_next = ACK;
        ACK:     w_next = !w_ready_s ? ADV : w_to ? IDLE : ACK;
        ADV:     w_next = (w_last && CONTINUOUS == 0) ? DONE : REQ;
        DONE:    w_next = start_n ? IDLE : DONE;
        default: w_next = IDLE;
      endcase
    if (abort) w_next = IDLE;
  end

  // state, ready synchronizer, index, counters and sticky flags
  always_ff @(posedge clk)
    if (!rst) begin
      r_state   <= IDLE;
      r_sync    <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_timer   <= '0;
      r_wrapped <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], byte_ready};
      r_state <= w_next;
      if (w_tick && !abort)
        case (r_state)
          IDLE: if (!start_n) begin
            r_cnt     <= '0;
            r_wrapped <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
          end
          CAP: r_timer <= '0;
          ACK: if (w_ready_s) begin
            r_timer <= r_timer + 1'b1;
            if (w_to) r_err <= 1'b1;
          end
          ADV: begin
            r_cnt <= (r_cnt == CW'(DEPTH)) ? r_cnt : r_cnt + 1'b1;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
            if (w_last && CONTINUOUS != 0) r_wrapped <= 1'b1;
            if (w_last && CONTINUOUS == 0) r_done <= 1'b1;
          end
          default: ;
        endcase
      if (w_next == IDLE) r_idx <= '0;
    end

  // buffer write: word latched as CAP hands over to ACK
  always_ff @(posedge clk)
    if (rst && r_state == CAP && w_tick && !abort) r_mem[r_idx] <= byte_in;

  // registered read port and display tap; same-cycle writes are seen next cycle
  always_ff @(posedge clk)
    if (!rst) begin
      rd_data  <= '0;
      tap_data <= '0;
    end else begin
      rd_data  <= (int'(rd_addr) < DEPTH) ? r_mem[rd_addr] : '0;
      tap_data <= r_mem[TAP_IDX];
    end
endmodule

// File: tb/tb_gpio_rx_buffer.sv
// tb_gpio_rx_buffer: one-shot, continuous, timeout, abort and collision checks against a buffer model
module tb_gpio_rx_buffer;
  typedef struct {
    logic [5:0] addr;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic clk = 0, rst = 0;
  logic sn0 = 1, ab0 = 0, br0 = 0, sn1 = 1, ab1 = 0, br1 = 0;
  logic [7:0] bi0 = 0, bi1 = 0, rd0, tap0, rd1, tap1;
  logic [5:0] ra0 = 0, cnt0;
  logic [1:0] ra1 = 0;
  logic [2:0] cnt1;
  logic req0, ack0, wr0, dn0, er0, req1, ack1, wr1, dn1, er1;
  int checks = 0, errors = 0;

  gpio_rx_buffer #(.DATA_W(8), .DEPTH(40), .CLK_DIV(4), .CONTINUOUS(0), .ACK_TO(8), .TAP_IDX(8)) dut0 (
    .clk(clk), .rst(rst), .start_n(sn0), .abort(ab0), .readssr_req(req0), .byte_ready(br0),
    .byte_in(bi0), .byte_ack(ack0), .rd_addr(ra0), .rd_data(rd0), .tap_data(tap0), .count(cnt0),
    .wrapped(wr0), .done(dn0), .err_timeout(er0));

  gpio_rx_buffer #(.DATA_W(8), .DEPTH(4), .CLK_DIV(1), .CONTINUOUS(1), .ACK_TO(255), .TAP_IDX(1)) dut1 (
    .clk(clk), .rst(rst), .start_n(sn1), .abort(ab1), .readssr_req(req1), .byte_ready(br1),
    .byte_in(bi1), .byte_ack(ack1), .rd_addr(ra1), .rd_data(rd1), .tap_data(tap1), .count(cnt1),
    .wrapped(wr1), .done(dn1), .err_timeout(er1));

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic sig(input int d, input int w);
    return w == 0 ? (d != 0 ? req1 : req0) : w == 1 ? (d != 0 ? ack1 : ack0) : (d != 0 ? dn1 : dn0);
  endfunction

  task automatic wait_for(input int d, input int w, input logic lvl, input string nm);
    int n = 0;
    while (sig(d, w) !== lvl && n < 400) begin
      cyc(1);
      n++;
    end
    chk(nm, 64'(sig(d, w)), 64'(lvl));
  endtask

  // reader side of the 4-phase handshake; optional read-before-write check on dut0
  task automatic send(input int d, input logic [7:0] v, input bit coll, input logic [7:0] old);
    wait_for(d, 0, 1'b1, "req_rise");
    if (d != 0) begin bi1 = v; br1 = 1; end else begin bi0 = v; br0 = 1; end
    wait_for(d, 1, 1'b1, "ack_rise");
    if (coll) begin
      chk("collision_old", 64'(rd0), 64'(old));
      cyc(1);
      chk("collision_new", 64'(rd0), 64'(v));
    end
    if (d != 0) br1 = 0; else br0 = 0;
    wait_for(d, 1, 1'b0, "ack_fall");
  endtask

  initial begin
    vec_t tbl[6];
    logic [7:0] model[40];
    logic [7:0] cm[4];
    logic [7:0] ring_exp[4];
    logic [7:0] v;
    tbl[0] = '{6'd0,  8'h00, "rd_first"};
    tbl[1] = '{6'd39, 8'h27, "rd_last"};
    tbl[2] = '{6'd8,  8'h08, "rd_tap_entry"};
    tbl[3] = '{6'd17, 8'h11, "rd_mid"};
    tbl[4] = '{6'd40, 8'h00, "rd_oob_40"};
    tbl[5] = '{6'd63, 8'h00, "rd_oob_63"};
    ring_exp[0] = 8'hA4; ring_exp[1] = 8'hA5; ring_exp[2] = 8'hA2; ring_exp[3] = 8'hA3;

    rst = 0;
    cyc(3);
    chk("rst_req", 64'(req0), 0); chk("rst_ack", 64'(ack0), 0); chk("rst_cnt", 64'(cnt0), 0);
    chk("rst_done", 64'(dn0), 0); chk("rst_err", 64'(er0), 0); chk("rst_rd", 64'(rd0), 0);
    chk("rst_tap", 64'(tap0), 0); chk("rst_wrap", 64'(wr0), 0); chk("rst_req1", 64'(req1), 0);
    chk("rst_cnt1", 64'(cnt1), 0);
    rst = 1;
    cyc(20);
    chk("idle_no_req", 64'(req0), 0);

    sn0 = 0;
    for (int i = 0; i < 40; i++) begin
      send(0, 8'(i), 0, 8'h00);
      model[i] = 8'(i);
    end
    wait_for(0, 2, 1'b1, "oneshot_done");
    chk("oneshot_count", 64'(cnt0), 40);
    chk("oneshot_tap", 64'(tap0), 8'h08);
    cyc(40);
    chk("held_start_no_retrigger", 64'(req0), 0);
    chk("done_held", 64'(dn0), 1);
    foreach (tbl[k]) begin
      ra0 = tbl[k].addr;
      cyc(2);
      chk(tbl[k].name, 64'(rd0), 64'(tbl[k].exp));
    end

    sn0 = 1;
    cyc(8);
    sn0 = 0;
    wait_for(0, 0, 1'b1, "restart_req");
    chk("restart_count_clear", 64'(cnt0), 0);
    chk("restart_done_clear", 64'(dn0), 0);
    for (int i = 0; i < 40; i++) begin
      v = (i == 17) ? 8'h5A : 8'($urandom);
      ra0 = 6'(i);
      send(0, v, 1, model[i]);
      model[i] = v;
    end
    wait_for(0, 2, 1'b1, "rand_done");
    chk("rand_count", 64'(cnt0), 40);
    chk("rand_tap", 64'(tap0), 64'(model[8]));
    for (int i = 0; i < 40; i++) begin
      ra0 = 6'(i);
      cyc(2);
      chk("rand_rd", 64'(rd0), 64'(model[i]));
    end

    sn0 = 1;
    cyc(8);
    sn0 = 0;
    wait_for(0, 0, 1'b1, "to_req");
    sn0 = 1;
    bi0 = 8'hEE;
    br0 = 1;
    wait_for(0, 1, 1'b1, "to_ack");
    cyc(28);
    chk("to_not_early", 64'(er0), 0);
    chk("to_ack_held", 64'(ack0), 1);
    cyc(8);
    chk("to_err", 64'(er0), 1);
    chk("to_ack_drop", 64'(ack0), 0);
    chk("to_req_drop", 64'(req0), 0);
    chk("to_count", 64'(cnt0), 0);
    ra0 = 0;
    cyc(2);
    chk("to_word_kept", 64'(rd0), 8'hEE);
    br0 = 0;
    cyc(20);
    chk("to_idle", 64'(req0), 0);
    chk("to_err_sticky", 64'(er0), 1);

    sn0 = 0;
    wait_for(0, 0, 1'b1, "ab_req");
    chk("ab_err_clear", 64'(er0), 0);
    send(0, 8'h33, 0, 8'h00);
    wait_for(0, 0, 1'b1, "ab_req2");
    bi0 = 8'h44;
    br0 = 1;
    wait_for(0, 1, 1'b1, "ab_ack");
    ab0 = 1;
    sn0 = 1;
    cyc(1);
    ab0 = 0;
    chk("ab_ack_drop", 64'(ack0), 0);
    chk("ab_req_drop", 64'(req0), 0);
    chk("ab_count_kept", 64'(cnt0), 1);
    br0 = 0;
    cyc(12);
    chk("ab_idle", 64'(req0), 0);
    sn0 = 0;
    wait_for(0, 0, 1'b1, "ab_restart_req");
    chk("ab_restart_count", 64'(cnt0), 0);
    ra0 = 0;
    send(0, 8'h77, 1, 8'h33);

    sn1 = 0;
    for (int i = 0; i < 10; i++) begin
      v = (i < 6) ? 8'hA0 + 8'(i) : 8'($urandom);
      send(1, v, 0, 8'h00);
      cm[i % 4] = v;
      if (i == 2 || i == 5 || i == 9) begin
        cyc(3);
        chk("ring_count", 64'(cnt1), (i + 1 < 4) ? i + 1 : 4);
        chk("ring_wrapped", 64'(wr1), (i + 1 >= 4) ? 1 : 0);
        chk("ring_no_done", 64'(dn1), 0);
      end
      if (i == 5)
        for (int k = 0; k < 4; k++) begin
          ra1 = 2'(k);
          cyc(2);
          chk("ring_spec_rd", 64'(rd1), 64'(ring_exp[k]));
        end
    end
    for (int k = 0; k < 4; k++) begin
      ra1 = 2'(k);
      cyc(2);
      chk("ring_rand_rd", 64'(rd1), 64'(cm[k]));
    end
    chk("ring_tap", 64'(tap1), 64'(cm[1]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
